// File: rtl/pipeline_controller_pkg.sv
// rtl/pipeline_controller_pkg.sv - shared types and defaults for the pipeline controller
package pipeline_controller_pkg;

  localparam int CNT_W_DEFAULT        = 32;
  localparam int DRAIN_CYCLES_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  // Width of the drain down-counter able to hold the full drain length.
  function automatic int drain_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// rtl/pipeline_controller_if.sv - hazard events in, pipeline register controls out
interface pipeline_controller_if;

  logic data_hazard;
  logic mispredict_ex;
  logic dmem_busy;
  logic halt_id;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_write;
  logic id_ex_bubble;
  logic ex_mem_write;
  logic mem_wb_bubble;
  logic is_halted;

  modport master (
    input  data_hazard, mispredict_ex, dmem_busy, halt_id,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, is_halted
  );

  modport slave (
    output data_hazard, mispredict_ex, dmem_busy, halt_id,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, is_halted
  );

endinterface

// File: rtl/pipeline_controller_sat_counter.sv
// rtl/pipeline_controller_sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - five-stage pipeline stall/flush/halt sequencer
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_controller_if.master ctrl,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int DRAIN_W = drain_width(DRAIN_CYCLES);

  pc_state_e          state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               stall_inc;
  logic               flush_inc;

  // State and drain counter registers; reset lands in RUN from any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Priority decode of pipeline events into register controls and next state.
  always_comb begin
    ctrl.pc_write      = 1'b1;
    ctrl.if_id_write   = 1'b1;
    ctrl.if_id_flush   = 1'b0;
    ctrl.id_ex_write   = 1'b1;
    ctrl.id_ex_bubble  = 1'b0;
    ctrl.ex_mem_write  = 1'b1;
    ctrl.mem_wb_bubble = 1'b0;
    ctrl.is_halted     = 1'b0;
    state_d            = state_q;
    drain_d            = drain_q;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ctrl.dmem_busy) begin
          // Whole front of the pipe waits; MEM/WB gets a NOP meanwhile.
          ctrl.pc_write      = 1'b0;
          ctrl.if_id_write   = 1'b0;
          ctrl.id_ex_write   = 1'b0;
          ctrl.ex_mem_write  = 1'b0;
          ctrl.mem_wb_bubble = 1'b1;
          stall_inc          = 1'b1;
        end else if (ctrl.mispredict_ex) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          flush_inc         = 1'b1;
        end else if (ctrl.data_hazard) begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
          stall_inc         = 1'b1;
        end else if (ctrl.halt_id) begin
          // The halt itself moves on into EX; nothing younger follows it.
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_flush = 1'b1;
          drain_d          = DRAIN_W'(DRAIN_CYCLES);
          state_d          = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (ctrl.dmem_busy) begin
          ctrl.pc_write      = 1'b0;
          ctrl.if_id_write   = 1'b0;
          ctrl.id_ex_write   = 1'b0;
          ctrl.ex_mem_write  = 1'b0;
          ctrl.mem_wb_bubble = 1'b1;
          stall_inc          = 1'b1;
        end else if (ctrl.mispredict_ex) begin
          // An older branch redirected, so the halt was on the wrong path.
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          flush_inc         = 1'b1;
          drain_d           = '0;
          state_d           = ST_RUN;
        end else begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          stall_inc         = 1'b1;
          drain_d           = drain_q - DRAIN_W'(1);
          if (drain_q == DRAIN_W'(1)) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        ctrl.pc_write     = 1'b0;
        ctrl.if_id_write  = 1'b0;
        ctrl.id_ex_write  = 1'b0;
        ctrl.ex_mem_write = 1'b0;
        ctrl.is_halted    = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (stall_inc),
    .count   (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (flush_inc),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed scenarios against a per-cycle reference model
module tb_pipeline_controller;

  localparam int CNT_W = 32;
  localparam int DRAIN = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  pipeline_controller_if pif ();

  pipeline_controller #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl        (pif.master),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef enum {A_IDLE, A_FREEZE, A_FLUSH, A_STALL, A_HALT, A_DRAIN, A_HALTED} act_e;

  bit               m_halted;
  int               m_left;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;

  // Order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble, is_halted
  localparam logic [7:0] O_IDLE   = 8'b1101_0100;
  localparam logic [7:0] O_FREEZE = 8'b0000_0010;
  localparam logic [7:0] O_FLUSH  = 8'b1111_1100;
  localparam logic [7:0] O_STALL  = 8'b0001_1100;
  localparam logic [7:0] O_HALT   = 8'b0111_0100;
  localparam logic [7:0] O_DRAIN  = 8'b0111_1100;
  localparam logic [7:0] O_HALTED = 8'b0000_0001;

  function automatic act_e cur_act();
    if (m_halted)          return A_HALTED;
    if (pif.dmem_busy)     return A_FREEZE;
    if (pif.mispredict_ex) return A_FLUSH;
    if (m_left > 0)        return A_DRAIN;
    if (pif.data_hazard)   return A_STALL;
    if (pif.halt_id)       return A_HALT;
    return A_IDLE;
  endfunction

  function automatic logic [7:0] act_outs(input act_e a);
    case (a)
      A_FREEZE: return O_FREEZE;
      A_FLUSH:  return O_FLUSH;
      A_STALL:  return O_STALL;
      A_HALT:   return O_HALT;
      A_DRAIN:  return O_DRAIN;
      A_HALTED: return O_HALTED;
      default:  return O_IDLE;
    endcase
  endfunction

  function automatic logic [7:0] dut_outs();
    return {pif.pc_write, pif.if_id_write, pif.if_id_flush, pif.id_ex_write,
            pif.id_ex_bubble, pif.ex_mem_write, pif.mem_wb_bubble, pif.is_halted};
  endfunction

  // Reference model: advance halt/drain bookkeeping and counters each clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_halted = 1'b0;
      m_left   = 0;
      m_stall  = '0;
      m_flush  = '0;
    end else begin
      act_e a;
      a = cur_act();
      if ((a == A_FREEZE || a == A_STALL || a == A_DRAIN) && m_stall != '1) m_stall = m_stall + 1'b1;
      if (a == A_FLUSH && m_flush != '1) m_flush = m_flush + 1'b1;
      case (a)
        A_FLUSH: m_left = 0;
        A_HALT:  m_left = DRAIN;
        A_DRAIN: begin
          m_left = m_left - 1;
          if (m_left == 0) m_halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of DUT outputs and counters against the model.
  always @(negedge clk) begin
    logic [7:0] exp_o;
    exp_o = act_outs(cur_act());
    vectors++;
    if (dut_outs() !== exp_o) begin
      miscompares++;
      $display("FAIL cycle_outs t=%0t got=%b want=%b", $time, dut_outs(), exp_o);
    end
    if (stall_count !== m_stall) begin
      miscompares++;
      $display("FAIL cycle_stall t=%0t got=%0d want=%0d", $time, stall_count, m_stall);
    end
    if (flush_count !== m_flush) begin
      miscompares++;
      $display("FAIL cycle_flush t=%0t got=%0d want=%0d", $time, flush_count, m_flush);
    end
  end

  task automatic chk(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic setin(input bit haz, input bit mis, input bit busy, input bit halt);
    pif.data_hazard   = haz;
    pif.mispredict_ex = mis;
    pif.dmem_busy     = busy;
    pif.halt_id       = halt;
  endtask

  task automatic cyc(input bit haz, input bit mis, input bit busy, input bit halt);
    setin(haz, mis, busy, halt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    setin(0, 0, 0, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;

    setin(0, 0, 0, 0);
    #3;
    chk("reset_outs_idle", CNT_W'(dut_outs()), CNT_W'(O_IDLE));
    chk("reset_stall", stall_count, 0);
    chk("reset_flush", flush_count, 0);
    setin(1, 0, 0, 0);
    #1;
    chk("reset_outs_hazard", CNT_W'(dut_outs()), CNT_W'(O_STALL));
    @(posedge clk);
    #1;
    chk("reset_hold_stall", stall_count, 0);
    reset_n = 1'b1;

    // Two-cycle data hazard.
    do_reset();
    setin(1, 0, 0, 0);
    #1;
    chk("hz_pc_write", CNT_W'(pif.pc_write), 0);
    chk("hz_bubble", CNT_W'(pif.id_ex_bubble), 1);
    @(posedge clk); #1;
    cyc(1, 0, 0, 0);
    setin(0, 0, 0, 0);
    chk("hz_stall", stall_count, 2);
    chk("hz_flush", flush_count, 0);

    // Memory busy outranks a same-cycle mispredict.
    do_reset();
    setin(1, 1, 1, 1);
    #1;
    chk("busy_mis_outs", CNT_W'(dut_outs()), CNT_W'(O_FREEZE));
    @(posedge clk); #1;
    chk("busy_mis_flush", flush_count, 0);
    setin(0, 1, 0, 0);
    #1;
    chk("mis_if_id_flush", CNT_W'(pif.if_id_flush), 1);
    @(posedge clk); #1;
    setin(0, 0, 0, 0);
    chk("mis_flush", flush_count, 1);
    chk("mis_stall", stall_count, 1);

    // Plain halt drains in three cycles.
    do_reset();
    cyc(0, 0, 0, 1);
    n = 0;
    while (!pif.is_halted && n < 20) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("halt_latency", CNT_W'(n), 3);
    chk("halt_stall", stall_count, 3);
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 1);
    chk("halted_stall_frozen", stall_count, 3);
    chk("halted_flush_frozen", flush_count, 0);
    chk("halted_flag", CNT_W'(pif.is_halted), 1);

    // Memory busy during drain pushes halted out by two cycles.
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 1);
    n = 3;
    while (!pif.is_halted && n < 20) begin
      cyc(1, 0, 0, 1);
      n++;
    end
    chk("halt_busy_latency", CNT_W'(n), 5);
    chk("halt_busy_stall", stall_count, 5);

    // Mispredict right after halt cancels the drain.
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      seen |= pif.is_halted;
    end
    chk("cancel_never_halted", CNT_W'(seen), 0);
    chk("cancel_flush", flush_count, 1);
    chk("cancel_stall", stall_count, 0);
    chk("cancel_pc_write", CNT_W'(pif.pc_write), 1);

    // Saturation from a preloaded stall counter, then reset mid-drain.
    do_reset();
    force dut.u_stall_cnt.count_q = {CNT_W{1'b1}};
    m_stall = {CNT_W{1'b1}};
    #1;
    release dut.u_stall_cnt.count_q;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("sat_stall", stall_count, {CNT_W{1'b1}});
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("pre_reset_flush", flush_count, 1);
    chk("pre_reset_draining", CNT_W'(pif.id_ex_bubble), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_stall", stall_count, 0);
    chk("async_flush", flush_count, 0);
    chk("async_outs", CNT_W'(dut_outs()), CNT_W'(O_IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk("post_reset_halted", CNT_W'(pif.is_halted), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, cycles from halt acceptance to halted (ID->EX->MEM->WB).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 data_hazard  in  1  stall request from hazard detection (ID operand depends on in-flight write).
REQ-006 mispredict_ex  in  1  EX-stage branch/jump redirect; IF and ID hold wrong-path instructions.
REQ-007 dmem_busy  in  1  data memory has not completed the MEM-stage access this cycle.
REQ-008 halt_id  in  1  halt (ecall) decoded in ID.
REQ-009 pc_write  out  1  PC register enable.
REQ-010 if_id_write  out  1  IF/ID register enable.
REQ-011 if_id_flush  out  1  load NOP into IF/ID.
REQ-012 id_ex_write  out  1  ID/EX register enable.
REQ-013 id_ex_bubble  out  1  load NOP into ID/EX (takes effect only when id_ex_write=1).
REQ-014 ex_mem_write  out  1  EX/MEM register enable.
REQ-015 mem_wb_bubble  out  1  load NOP into MEM/WB.
REQ-016 is_halted  out  1  pipeline drained after halt.
REQ-017 stall_count  out  CNT_W  cycles with pc_write=0 outside HALTED.
REQ-018 flush_count  out  CNT_W  accepted mispredict flushes.

Function
REQ-019 SHALL implement FSM states RUN, DRAIN, HALTED; control outputs SHALL be combinational from state and inputs.
REQ-020 Default (RUN, no input asserted): all *_write=1, all flush/bubble=0, is_halted=0.
REQ-021 Event priority in RUN: dmem_busy > mispredict_ex > data_hazard > halt_id; only the highest SHALL act.
REQ-022 dmem_busy: pc_write, if_id_write, id_ex_write, ex_mem_write=0; mem_wb_bubble=1; stall_count+1; no state change.
REQ-023 mispredict_ex: pc_write=1, if_id_flush=1, id_ex_bubble=1; flush_count+1; state stays RUN.
REQ-024 data_hazard: pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count+1.
REQ-025 halt_id: pc_write=0, if_id_flush=1, ID/EX loads halt instruction normally; load drain_cnt=DRAIN_CYCLES; next state DRAIN.
REQ-026 DRAIN: pc_write=0, if_id_flush=1, id_ex_bubble=1; stall_count+1 per cycle; drain_cnt-1 per cycle without dmem_busy.
REQ-027 DRAIN with dmem_busy: freeze per REQ-022, drain_cnt holds.
REQ-028 DRAIN with drain_cnt=1 and no dmem_busy: next state HALTED.
REQ-029 DRAIN with mispredict_ex and no dmem_busy: halt was wrong-path; apply REQ-023, clear drain_cnt, return to RUN.
REQ-030 HALTED: all *_write=0, is_halted=1, counters frozen, inputs ignored; exit only by reset.
REQ-031 Counters SHALL saturate at all-ones, never wrap.
REQ-032 data_hazard and halt_id SHALL be ignored in DRAIN.

Reset
REQ-033 reset_n=0 SHALL immediately set state=RUN, drain_cnt=0, stall_count=0, flush_count=0, valid mid-DRAIN or mid-freeze.
REQ-034 During reset, outputs SHALL equal RUN-state values for current inputs; is_halted=0.

Structure
REQ-035 State enum, DRAIN_CYCLES default and CNT_W default SHALL live in the shared pipeline package.
REQ-036 One sub-module sat_counter (enable, async active-low reset, saturate), instantiated twice.

Verification
REQ-037 data_hazard=1 for 2 cycles from RUN -> pc_write=0, id_ex_bubble=1 both cycles; stall_count=2; flush_count=0.
REQ-038 dmem_busy=1 with mispredict_ex=1 same cycle -> freeze only, flush_count unchanged; next cycle mispredict alone -> if_id_flush=1, flush_count=1.
REQ-039 halt_id=1 once, no other events -> DRAIN for 3 cycles, is_halted=1 on 4th cycle; stall_count=3.
REQ-040 halt_id, then dmem_busy for 2 cycles during DRAIN -> is_halted rises 2 cycles later than REQ-039 case.
REQ-041 halt_id, then mispredict_ex next cycle -> state RUN, is_halted never asserts, flush_count=1.
REQ-042 Preload stall_count to all-ones via force, data_hazard=1 -> remains all-ones; reset_n low mid-DRAIN -> RUN, counters 0 asynchronously.
